// File: rtl/decode_sequencer_if.sv
// rtl/decode_sequencer_if.sv - handshake and decode-bundle bundle for decode_sequencer
//
// Purpose: groups the instruction input stream, the decode bundle output stream
//          and the register-file read strobes of the decode stage.
// Ports (signals):
//   in_valid/in_ready/in_instr   instruction offer, stage accept, 16-bit word
//   out_valid/out_ready          decode bundle valid, downstream consume
//   opcode, op, cond, is_branch, shift, rd_idx, rn_idx, rm_idx, sximm5, sximm8, illegal
//   rd_en/nsel/readnum           read port A strobe, one-hot select, index
//   rd_en_b/readnum_b            read port B strobe and index (Rm)
// Modports: slave = decode stage, master = producer/consumer side.

interface decode_sequencer_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [2:0]    cond;
    logic          is_branch;
    logic [1:0]    shift;
    logic [2:0]    rd_idx;
    logic [2:0]    rn_idx;
    logic [2:0]    rm_idx;
    logic [DW-1:0] sximm5;
    logic [DW-1:0] sximm8;
    logic          rd_en;
    logic [2:0]    nsel;
    logic [2:0]    readnum;
    logic [2:0]    readnum_b;
    logic          rd_en_b;
    logic          illegal;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, opcode, op, cond, is_branch, shift,
               rd_idx, rn_idx, rm_idx, sximm5, sximm8,
               rd_en, nsel, readnum, readnum_b, rd_en_b, illegal
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, opcode, op, cond, is_branch, shift,
               rd_idx, rn_idx, rm_idx, sximm5, sximm8,
               rd_en, nsel, readnum, readnum_b, rd_en_b, illegal
    );
endinterface

// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - registered handshaked instruction decode and operand read sequencer
//
// Purpose: accepts one 16-bit Simple RISC Machine instruction, registers its decoded
//          fields and sign-extended immediates, then walks the register-file read
//          select (one-hot nsel) through the operands of that instruction class and
//          holds the bundle valid until downstream consumes it.
// Parameters: DW  datapath width for sximm5/sximm8
//             NRP register-file read ports (1 or 2); with 2 the Rn,Rm pair is read at once
// Ports: clk      rising-edge clock
//        reset_n  asynchronous active-low reset
//        bus      decode_sequencer_if.slave (streams, decode bundle, read strobes)
// Optional: DECODE_ILLEGAL_EN - when defined, unlisted encodings raise illegal with the bundle.

module decode_sequencer #(
    parameter int DW  = 16,
    parameter int NRP = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    decode_sequencer_if.slave    bus
);

    localparam logic [2:0] SEL_RN = 3'b100;
    localparam logic [2:0] SEL_RD = 3'b010;
    localparam logic [2:0] SEL_RM = 3'b001;

    typedef enum logic [1:0] {IDLE, RD_A, RD_B, HOLD} state_t;

    state_t     state;
    logic [2:0] sel_b;
    logic       pend_b;
    logic       accept;

    logic [2:0] i_opc, i_rn, i_rd, i_rm;
    logic [1:0] i_op;

    logic [1:0] d_nrd;
    logic [2:0] d_s1, d_s2, d_cond;
    logic [1:0] d_shift;
    logic       d_br;
    logic       d_pair;

    assign i_opc = bus.in_instr[15:13];
    assign i_op  = bus.in_instr[12:11];
    assign i_rn  = bus.in_instr[10:8];
    assign i_rd  = bus.in_instr[7:5];
    assign i_rm  = bus.in_instr[2:0];

    assign bus.in_ready = (state == IDLE) | ((state == HOLD) & bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    // Operand read list and control fields of the instruction being offered.
    always_comb begin
        d_nrd   = 2'd0;
        d_s1    = 3'b000;
        d_s2    = 3'b000;
        d_cond  = 3'b000;
        if (i_opc == 3'b101) begin
            if (i_op != 2'b11) begin
                d_nrd = 2'd2;
                d_s1  = SEL_RN;
                d_s2  = SEL_RM;
            end else begin
                d_nrd = 2'd1;
                d_s1  = SEL_RM;
            end
        end else begin
            case ({i_opc, i_op})
                5'b110_00: begin d_nrd = 2'd1; d_s1 = SEL_RM; end
                5'b011_00: begin d_nrd = 2'd1; d_s1 = SEL_RN; end
                5'b100_00: begin d_nrd = 2'd2; d_s1 = SEL_RN; d_s2 = SEL_RD; end
                5'b010_00,
                5'b010_10: begin d_nrd = 2'd1; d_s1 = SEL_RD; end
                default:   ;
            endcase
        end
        case ({i_opc, i_op})
            5'b001_00: d_cond = i_rn;
            5'b010_11: d_cond = 3'b101;
            5'b010_00: d_cond = 3'b110;
            5'b010_10: d_cond = 3'b111;
            default:   d_cond = 3'b000;
        endcase
        d_br    = (i_opc == 3'b001) | (i_opc == 3'b010);
        d_shift = (d_br | ({i_opc, i_op} == 5'b100_00)) ? 2'b00 : bus.in_instr[4:3];
    end

    // Only the ALU Rn,Rm pair can be split across the two read ports.
    assign d_pair = (NRP == 2) && (d_nrd == 2'd2) && (d_s2 == SEL_RM);

`ifdef DECODE_ILLEGAL_EN
    logic d_legal;
    assign d_legal = (i_opc == 3'b101)
                   | ((i_opc == 3'b110) & ((i_op == 2'b00) | (i_op == 2'b10)))
                   | ({i_opc, i_op} == 5'b011_00)
                   | ({i_opc, i_op} == 5'b100_00)
                   | ({i_opc, i_op} == 5'b001_00)
                   | ((i_opc == 3'b010) & (i_op != 2'b01));
`endif

    function automatic logic [2:0] pick(input logic [2:0] sel, input logic [2:0] rn,
                                        input logic [2:0] rd, input logic [2:0] rm);
        case (sel)
            SEL_RN:  pick = rn;
            SEL_RD:  pick = rd;
            SEL_RM:  pick = rm;
            default: pick = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sel_b         <= 3'b000;
            pend_b        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.opcode    <= 3'b000;
            bus.op        <= 2'b00;
            bus.cond      <= 3'b000;
            bus.is_branch <= 1'b0;
            bus.shift     <= 2'b00;
            bus.rd_idx    <= 3'b000;
            bus.rn_idx    <= 3'b000;
            bus.rm_idx    <= 3'b000;
            bus.sximm5    <= '0;
            bus.sximm8    <= '0;
            bus.rd_en     <= 1'b0;
            bus.nsel      <= 3'b000;
            bus.readnum   <= 3'b000;
            bus.readnum_b <= 3'b000;
            bus.rd_en_b   <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (accept) begin
            // Bundle fields are captured on the accept edge and then held.
            bus.opcode    <= i_opc;
            bus.op        <= i_op;
            bus.cond      <= d_cond;
            bus.is_branch <= d_br;
            bus.shift     <= d_shift;
            bus.rd_idx    <= i_rd;
            bus.rn_idx    <= i_rn;
            bus.rm_idx    <= i_rm;
            bus.sximm5    <= {{(DW-5){bus.in_instr[4]}}, bus.in_instr[4:0]};
            bus.sximm8    <= {{(DW-8){bus.in_instr[7]}}, bus.in_instr[7:0]};
`ifdef DECODE_ILLEGAL_EN
            bus.illegal   <= ~d_legal;
`else
            bus.illegal   <= 1'b0;
`endif
            sel_b         <= d_s2;
            pend_b        <= (d_nrd == 2'd2) & ~d_pair;
            bus.rd_en_b   <= d_pair;
            bus.readnum_b <= d_pair ? i_rm : 3'b000;
            if (d_nrd == 2'd0) begin
                state         <= HOLD;
                bus.out_valid <= 1'b1;
                bus.rd_en     <= 1'b0;
                bus.nsel      <= 3'b000;
                bus.readnum   <= 3'b000;
            end else begin
                state         <= RD_A;
                bus.out_valid <= 1'b0;
                bus.rd_en     <= 1'b1;
                bus.nsel      <= d_s1;
                bus.readnum   <= pick(d_s1, i_rn, i_rd, i_rm);
            end
        end else begin
            case (state)
                RD_A: begin
                    bus.rd_en_b   <= 1'b0;
                    bus.readnum_b <= 3'b000;
                    if (pend_b) begin
                        state       <= RD_B;
                        bus.nsel    <= sel_b;
                        bus.readnum <= pick(sel_b, bus.rn_idx, bus.rd_idx, bus.rm_idx);
                    end else begin
                        state         <= HOLD;
                        bus.out_valid <= 1'b1;
                        bus.rd_en     <= 1'b0;
                        bus.nsel      <= 3'b000;
                        bus.readnum   <= 3'b000;
                    end
                end
                RD_B: begin
                    state         <= HOLD;
                    pend_b        <= 1'b0;
                    bus.out_valid <= 1'b1;
                    bus.rd_en     <= 1'b0;
                    bus.nsel      <= 3'b000;
                    bus.readnum   <= 3'b000;
                end
                HOLD: begin
                    // Consumed with nothing offered: drop back to IDLE.
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// tb/tb_decode_sequencer.sv - directed table-driven bench for decode_sequencer

module tb_decode_sequencer;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    decode_sequencer_if #(.DW(16)) if1 ();
    decode_sequencer_if #(.DW(16)) if2 ();

    decode_sequencer #(.DW(16), .NRP(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    decode_sequencer #(.DW(16), .NRP(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        int          nrd;
        logic [2:0]  s1, r1, s2, r2;
        logic [2:0]  cond;
        logic        br;
        logic [1:0]  shift;
        logic [2:0]  rd, rn, rm;
        logic [15:0] x5, x8;
        logic        ill;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic [15:0] instr, input int nrd,
                                input logic [2:0] s1, input logic [2:0] r1,
                                input logic [2:0] s2, input logic [2:0] r2,
                                input logic [2:0] cond, input logic br, input logic [1:0] shift,
                                input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                                input logic [15:0] x5, input logic [15:0] x8, input logic ill);
        vec_t v;
        v.instr = instr; v.nrd = nrd; v.s1 = s1; v.r1 = r1; v.s2 = s2; v.r2 = r2;
        v.cond = cond; v.br = br; v.shift = shift; v.rd = rd; v.rn = rn; v.rm = rm;
        v.x5 = x5; v.x8 = x8; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic       exp_ill;
        logic [2:0] s, r;
        string      tag;
`ifdef DECODE_ILLEGAL_EN
        exp_ill = v.ill;
`else
        exp_ill = 1'b0;
`endif
        tag = $sformatf("v%0d", idx);
        if1.in_valid  = 1'b1;
        if1.in_instr  = v.instr;
        if1.out_ready = 1'b0;
        chk({tag, ".in_ready_idle"}, {31'd0, if1.in_ready}, 32'd1);
        @(negedge clk);
        // Keep offering a different word: it must be ignored while busy.
        if1.in_instr = 16'hFFFF;
        for (int k = 0; k < v.nrd; k++) begin
            s = (k == 0) ? v.s1 : v.s2;
            r = (k == 0) ? v.r1 : v.r2;
            chk($sformatf("%s.rd_en%0d", tag, k),    {31'd0, if1.rd_en}, 32'd1);
            chk($sformatf("%s.nsel%0d", tag, k),     {29'd0, if1.nsel}, {29'd0, s});
            chk($sformatf("%s.readnum%0d", tag, k),  {29'd0, if1.readnum}, {29'd0, r});
            chk($sformatf("%s.rd_en_b%0d", tag, k),  {31'd0, if1.rd_en_b}, 32'd0);
            chk($sformatf("%s.outv_busy%0d", tag, k), {31'd0, if1.out_valid}, 32'd0);
            chk($sformatf("%s.inr_busy%0d", tag, k), {31'd0, if1.in_ready}, 32'd0);
            @(negedge clk);
        end
        chk({tag, ".out_valid"}, {31'd0, if1.out_valid}, 32'd1);
        chk({tag, ".rd_en_hold"}, {31'd0, if1.rd_en}, 32'd0);
        chk({tag, ".nsel_hold"}, {29'd0, if1.nsel}, 32'd0);
        chk({tag, ".opcode"}, {29'd0, if1.opcode}, {29'd0, v.instr[15:13]});
        chk({tag, ".op"}, {30'd0, if1.op}, {30'd0, v.instr[12:11]});
        chk({tag, ".cond"}, {29'd0, if1.cond}, {29'd0, v.cond});
        chk({tag, ".is_branch"}, {31'd0, if1.is_branch}, {31'd0, v.br});
        chk({tag, ".shift"}, {30'd0, if1.shift}, {30'd0, v.shift});
        chk({tag, ".rd_idx"}, {29'd0, if1.rd_idx}, {29'd0, v.rd});
        chk({tag, ".rn_idx"}, {29'd0, if1.rn_idx}, {29'd0, v.rn});
        chk({tag, ".rm_idx"}, {29'd0, if1.rm_idx}, {29'd0, v.rm});
        chk({tag, ".sximm5"}, {16'd0, if1.sximm5}, {16'd0, v.x5});
        chk({tag, ".sximm8"}, {16'd0, if1.sximm8}, {16'd0, v.x8});
        chk({tag, ".illegal"}, {31'd0, if1.illegal}, {31'd0, exp_ill});
        chk({tag, ".inr_hold"}, {31'd0, if1.in_ready}, 32'd0);
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b1;
        @(negedge clk);
        if1.out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, {31'd0, if1.out_valid}, 32'd0);
        chk({tag, ".in_ready_back"}, {31'd0, if1.in_ready}, 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        reset_n  = 1'b0;
        if1.in_valid = 1'b0; if1.in_instr = 16'h0000; if1.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.in_instr = 16'h0000; if2.out_ready = 1'b0;

        //           instr    n  s1      r1    s2      r2    cond    br    sh     rd      rn      rm      sximm5    sximm8    ill
        tbl[0]  = mk(16'hA140, 2, 3'b100, 3'd1, 3'b001, 3'd0, 3'b000, 1'b0, 2'b00, 3'd2, 3'd1, 3'd0, 16'h0000, 16'h0040, 1'b0);
        tbl[1]  = mk(16'hD3FB, 0, 3'b000, 3'd0, 3'b000, 3'd0, 3'b000, 1'b0, 2'b11, 3'd7, 3'd3, 3'd3, 16'hFFFB, 16'hFFFB, 1'b0);
        tbl[2]  = mk(16'h8182, 2, 3'b100, 3'd1, 3'b010, 3'd4, 3'b000, 1'b0, 2'b00, 3'd4, 3'd1, 3'd2, 16'h0002, 16'hFF82, 1'b0);
        tbl[3]  = mk(16'h23FD, 0, 3'b000, 3'd0, 3'b000, 3'd0, 3'b011, 1'b1, 2'b00, 3'd7, 3'd3, 3'd5, 16'hFFFD, 16'hFFFD, 1'b0);
        tbl[4]  = mk(16'hB8F5, 1, 3'b001, 3'd5, 3'b000, 3'd0, 3'b000, 1'b0, 2'b10, 3'd7, 3'd0, 3'd5, 16'hFFF5, 16'hFFF5, 1'b0);
        tbl[5]  = mk(16'h6244, 1, 3'b100, 3'd2, 3'b000, 3'd0, 3'b000, 1'b0, 2'b00, 3'd2, 3'd2, 3'd4, 16'h0004, 16'h0044, 1'b0);
        tbl[6]  = mk(16'h4060, 1, 3'b010, 3'd3, 3'b000, 3'd0, 3'b110, 1'b1, 2'b00, 3'd3, 3'd0, 3'd0, 16'h0000, 16'h0060, 1'b0);
        tbl[7]  = mk(16'h5F80, 0, 3'b000, 3'd0, 3'b000, 3'd0, 3'b101, 1'b1, 2'b00, 3'd4, 3'd7, 3'd0, 16'h0000, 16'hFF80, 1'b0);
        tbl[8]  = mk(16'h50E0, 1, 3'b010, 3'd7, 3'b000, 3'd0, 3'b111, 1'b1, 2'b00, 3'd7, 3'd0, 3'd0, 16'h0000, 16'hFFE0, 1'b0);
        tbl[9]  = mk(16'hC01A, 1, 3'b001, 3'd2, 3'b000, 3'd0, 3'b000, 1'b0, 2'b11, 3'd0, 3'd0, 3'd2, 16'hFFFA, 16'h001A, 1'b0);
        tbl[10] = mk(16'hE13B, 0, 3'b000, 3'd0, 3'b000, 3'd0, 3'b000, 1'b0, 2'b11, 3'd1, 3'd1, 3'd3, 16'hFFFB, 16'h003B, 1'b1);
        tbl[11] = mk(16'hB4BB, 2, 3'b100, 3'd4, 3'b001, 3'd3, 3'b000, 1'b0, 2'b11, 3'd5, 3'd4, 3'd3, 16'hFFFB, 16'hFFBB, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst.out_valid", {31'd0, if1.out_valid}, 32'd0);
        chk("rst.rd_en", {31'd0, if1.rd_en}, 32'd0);
        chk("rst.nsel", {29'd0, if1.nsel}, 32'd0);
        chk("rst.readnum", {29'd0, if1.readnum}, 32'd0);
        chk("rst.sximm8", {16'd0, if1.sximm8}, 32'd0);
        chk("rst.rd_en_b2", {31'd0, if2.rd_en_b}, 32'd0);
        chk("rst.in_ready", {31'd0, if1.in_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

        // Two read ports: ALU Rn,Rm pair in a single read cycle.
        if2.in_valid = 1'b1;
        if2.in_instr = 16'hA140;
        @(negedge clk);
        if2.in_valid = 1'b0;
        chk("nrp2.rd_en", {31'd0, if2.rd_en}, 32'd1);
        chk("nrp2.nsel", {29'd0, if2.nsel}, 32'd4);
        chk("nrp2.readnum", {29'd0, if2.readnum}, 32'd1);
        chk("nrp2.rd_en_b", {31'd0, if2.rd_en_b}, 32'd1);
        chk("nrp2.readnum_b", {29'd0, if2.readnum_b}, 32'd0);
        chk("nrp2.outv_busy", {31'd0, if2.out_valid}, 32'd0);
        @(negedge clk);
        chk("nrp2.out_valid", {31'd0, if2.out_valid}, 32'd1);
        chk("nrp2.rd_en_off", {31'd0, if2.rd_en}, 32'd0);
        chk("nrp2.rd_en_b_off", {31'd0, if2.rd_en_b}, 32'd0);
        if2.out_ready = 1'b1;
        @(negedge clk);
        if2.out_ready = 1'b0;
        chk("nrp2.idle", {31'd0, if2.out_valid}, 32'd0);

        // Branch held under backpressure, then back-to-back load of MOV imm.
        if1.in_valid = 1'b1;
        if1.in_instr = 16'h23FD;
        @(negedge clk);
        if1.in_instr = 16'hD3FB;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d.out_valid", k), {31'd0, if1.out_valid}, 32'd1);
            chk($sformatf("hold%0d.sximm8", k), {16'd0, if1.sximm8}, 32'h0000FFFD);
            chk($sformatf("hold%0d.cond", k), {29'd0, if1.cond}, 32'd3);
            chk($sformatf("hold%0d.is_branch", k), {31'd0, if1.is_branch}, 32'd1);
            chk($sformatf("hold%0d.in_ready", k), {31'd0, if1.in_ready}, 32'd0);
            @(negedge clk);
        end
        if1.out_ready = 1'b1;
        #1;
        chk("b2b.in_ready", {31'd0, if1.in_ready}, 32'd1);
        @(negedge clk);
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b0;
        chk("b2b.out_valid", {31'd0, if1.out_valid}, 32'd1);
        chk("b2b.opcode", {29'd0, if1.opcode}, 32'd6);
        chk("b2b.rn_idx", {29'd0, if1.rn_idx}, 32'd3);
        chk("b2b.sximm8", {16'd0, if1.sximm8}, 32'h0000FFFB);
        chk("b2b.is_branch", {31'd0, if1.is_branch}, 32'd0);
        if1.out_ready = 1'b1;
        @(negedge clk);
        if1.out_ready = 1'b0;

        // Reset pulsed during RD_B of an ADD.
        if1.in_valid = 1'b1;
        if1.in_instr = 16'hA140;
        @(negedge clk);
        if1.in_valid = 1'b0;
        @(negedge clk);
        chk("abort.rd_b_nsel", {29'd0, if1.nsel}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort.nsel", {29'd0, if1.nsel}, 32'd0);
        chk("abort.rd_en", {31'd0, if1.rd_en}, 32'd0);
        chk("abort.opcode", {29'd0, if1.opcode}, 32'd0);
        chk("abort.out_valid", {31'd0, if1.out_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort.no_valid%0d", k), {31'd0, if1.out_valid}, 32'd0);
        end
        run_vec(tbl[0], 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Registered, handshaked instruction-decode stage for the Simple RISC Machine.
- Captures one 16-bit instruction, decodes its fields and sign-extended immediates, then steps the register-file read index (one-hot nsel) through the operands that instruction class needs.
- Presents a stable decode bundle downstream until it is consumed.
- Successor to the combinational decoder: parametrised datapath width and read-port count, class-aware operand sequencing, valid/ready flow control.

Parameters:
- DW, 16, datapath width; sign-extension target for sximm5/sximm8.
- NRP, 1, register-file read ports (1 or 2); with 2, Rn and Rm are read in the same cycle.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  16  instruction word
- out_valid  out  1  decode bundle valid
- out_ready  in  1  downstream consumes bundle
- opcode  out  3  instr[15:13], registered
- op  out  2  instr[12:11], registered (also ALUop)
- cond  out  3  branch condition
- is_branch  out  1  opcode 001 or 010
- shift  out  2  shifter control
- rd_idx, rn_idx, rm_idx  out  3 each  instr[7:5], [10:8], [2:0]
- sximm5  out  DW  sign-extended instr[4:0]
- sximm8  out  DW  sign-extended instr[7:0]
- rd_en  out  1  read strobe, port A
- nsel  out  3  one-hot read select, port A: 100=Rn, 010=Rd, 001=Rm
- readnum  out  3  index selected by nsel
- readnum_b  out  3  port B index (Rm); driven only when NRP=2, else 0
- rd_en_b  out  1  port B strobe; only when NRP=2, else 0
- illegal  out  1  see Optional Feature

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - out_valid=0, rd_en=0, rd_en_b=0, nsel=000, readnum=0, readnum_b=0.
  - All decode outputs 0, illegal=0.
- States: IDLE, RD_A, RD_B, HOLD.
- Accept:
  - in_ready = (state==IDLE) | (state==HOLD & out_ready).
  - On in_valid & in_ready, latch instr and all decode outputs at that edge.
- Read list by class, in order:
  - ALU 101, op≠11: Rn, Rm.
  - MVN 101/11: Rm.
  - MOV reg 110/00: Rm.
  - MOV imm 110/10: none.
  - LDR 011/00: Rn.
  - STR 100/00: Rn, Rd.
  - B 001/00: none. BL 010/11: none.
  - BX 010/00: Rd. BLX 010/10: Rd.
- Sequencing:
  - RD_A drives the first list entry for exactly one cycle: rd_en=1, nsel, readnum.
  - RD_B drives the second entry.
  - With NRP=2, an Rn,Rm pair is issued in RD_A only (port A=Rn, port B=Rm), so RD_B is skipped.
  - After the last read, or directly for an empty list, go to HOLD with out_valid=1.
  - Latency from accept edge to out_valid: 1 + number of read cycles.
    - ADD: 3 cycles with NRP=1, 2 with NRP=2.
    - MOV imm: 1 cycle.
- HOLD:
  - All outputs are stable while out_ready=0.
  - out_ready & in_valid: load the next instruction the same edge (back-to-back).
  - out_ready & !in_valid: go to IDLE, out_valid=0.
- cond:
  - B: instr[10:8].
  - BL: 101. BX: 110. BLX: 111.
  - Non-branch: 000; meaningful only when is_branch=1.
- shift: 00 for STR and all branches; otherwise instr[4:3].
- Sign extension: replicate the MSB of the field to DW bits, with all source bits preserved. sximm8 = {{(DW-8){i[7]}}, i[7:0]}.
- rd_en/nsel/readnum are 0 outside RD_A/RD_B.
- in_valid while busy (RD_A/RD_B) is ignored (in_ready=0).
- reset_n asserted mid-sequence aborts immediately to reset values. No partial bundle is ever marked valid.

Optional Feature:
- Macro DECODE_ILLEGAL_EN.
- Defined:
  - illegal=1, registered with the bundle, for any opcode/op not in the read list, including opcodes 000 and 111.
  - Such instructions get an empty read list and proceed to HOLD.
- Undefined:
  - illegal tied 0.
  - Unlisted encodings decode with an empty read list and default shift/cond rules.

Test Plan:
- NRP=1, ADD 16'hA140 accepted at edge 0 -> edge 1: nsel=100, readnum=1; edge 2: nsel=001, readnum=0; edge 3: out_valid=1, rd_idx=2, shift=00.
- NRP=2, 16'hA140 -> single read cycle with readnum=1, readnum_b=0, rd_en_b=1; out_valid at edge 2.
- MOV imm 16'hD3FB -> no rd_en; out_valid next edge; rn_idx=3; sximm8=16'hFFFB.
- STR 16'h8182 -> reads readnum=1 (nsel 100) then readnum=4 (nsel 010); shift=00; sximm5=16'h0002.
- BLT 16'h23FD with out_ready=0 for 5 cycles -> is_branch=1, cond=011, sximm8=16'hFFFD held stable, in_ready=0. When out_ready=1 with in_valid=1 (16'hD3FB), the next instruction is accepted the same edge.
- reset_n pulsed low during RD_B of 16'hA140 -> outputs zero immediately, out_valid never asserted for that instruction; the next accept behaves normally.
